// File: rtl/pattern_scan_engine.sv
// pattern_scan_engine: counts 5-bit pattern matches over a 32-byte message in data memory and writes the three counts back; ports CLK/Reset, start/halt handshake, async-read data memory port, pat_in only with PSCAN_PAT_PORT_EN
module pattern_scan_engine #(
  parameter int MSG_BASE  = 0,
  parameter int NUM_BYTES = 32,
  parameter int PAT_ADDR  = 32,
  parameter int RES_ADDR  = 33
) (
  input  logic       CLK,
  input  logic       Reset,
  input  logic       start,
  output logic       halt,
  output logic [7:0] mem_addr,
  input  logic [7:0] mem_rd_data,
  output logic       mem_wr_en,
  output logic [7:0] mem_wr_data
`ifdef PSCAN_PAT_PORT_EN
  ,
  input  logic [4:0] pat_in
`endif
);
  typedef enum logic [2:0] {IDLE, LOAD_PAT, SCAN, WR_CTB, WR_CTO, WR_CTS, DONE} state_t;
  state_t state, state_n;
  logic [4:0] pat;
  logic [7:0] prev, ctb, cto, cts;
  logic [5:0] i;
  logic [3:0] in_hit, x_hit;
  logic [2:0] in_cnt, x_cnt;
  logic go;
  assign go = (state == IDLE || state == DONE) && start;
  always_comb begin
    in_hit = {mem_rd_data[7:3] == pat, mem_rd_data[6:2] == pat, mem_rd_data[5:1] == pat, mem_rd_data[4:0] == pat};
    x_hit = (i == 6'd0) ? 4'd0 :
            {{prev[3:0], mem_rd_data[7]} == pat, {prev[2:0], mem_rd_data[7:6]} == pat,
             {prev[1:0], mem_rd_data[7:5]} == pat, {prev[0], mem_rd_data[7:4]} == pat};
    in_cnt = {2'b0, in_hit[0]} + {2'b0, in_hit[1]} + {2'b0, in_hit[2]} + {2'b0, in_hit[3]};
    x_cnt = {2'b0, x_hit[0]} + {2'b0, x_hit[1]} + {2'b0, x_hit[2]} + {2'b0, x_hit[3]};
  end
  always_comb begin
    state_n = state;
    halt = state == DONE;
    mem_wr_en = state == WR_CTB || state == WR_CTO || state == WR_CTS;
    mem_addr = 8'd0;
    mem_wr_data = 8'd0;
    case (state)
`ifdef PSCAN_PAT_PORT_EN
      IDLE, DONE: state_n = start ? SCAN : state;
`else
      IDLE, DONE: state_n = start ? LOAD_PAT : state;
`endif
      LOAD_PAT: begin
        mem_addr = 8'(PAT_ADDR);
        state_n = SCAN;
      end
      SCAN: begin
        mem_addr = 8'(MSG_BASE) + {2'b0, i};
        state_n = (i == 6'(NUM_BYTES - 1)) ? WR_CTB : SCAN;
      end
      WR_CTB: begin
        mem_addr = 8'(RES_ADDR);
        mem_wr_data = ctb;
        state_n = WR_CTO;
      end
      WR_CTO: begin
        mem_addr = 8'(RES_ADDR + 1);
        mem_wr_data = cto;
        state_n = WR_CTS;
      end
      WR_CTS: begin
        mem_addr = 8'(RES_ADDR + 2);
        mem_wr_data = cts;
        state_n = DONE;
      end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state <= IDLE;
      pat <= 5'd0;
      prev <= 8'd0;
      ctb <= 8'd0;
      cto <= 8'd0;
      cts <= 8'd0;
      i <= 6'd0;
    end else begin
      state <= state_n;
      if (go) begin
        ctb <= 8'd0;
        cto <= 8'd0;
        cts <= 8'd0;
        i <= 6'd0;
        prev <= 8'd0;
`ifdef PSCAN_PAT_PORT_EN
        pat <= pat_in;
`endif
      end
      if (state == LOAD_PAT) pat <= mem_rd_data[7:3];
      if (state == SCAN) begin
        ctb <= ctb + {5'b0, in_cnt};
        cto <= cto + {7'b0, |in_hit};
        cts <= cts + {5'b0, in_cnt} + {5'b0, x_cnt};
        prev <= mem_rd_data;
        i <= i + 6'd1;
      end
    end
  end
endmodule
